pio_edge_in: RTL and testbench
==============================

# pio_edge_in

Parametrised Avalon-MM PIO input peripheral for the Qsys system. Successor to the fixed 8-bit input PIO. Adds:
- a configurable port width;
- input synchronisation;
- per-bit edge capture with write-1-to-clear;
- an interrupt mask;
- a level interrupt to the Nios II.

Sits on the system interconnect as a 4-word slave with one-cycle read latency.

## Interface
- `WIDTH`, 8: input port width, 1..32.
- `SYNC_STAGES`, 2: synchroniser flops on `in_port`, 0..3. Use 0 only for inputs already synchronous to `clk`.
- `EDGE_TYPE`, 0: capture condition. 0 = rising, 1 = falling, 2 = any edge.
- `clk` input 1: system clock; all logic on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `address` input 2: word address.
- `chipselect` input 1: slave select.
- `write_n` input 1: active-low write strobe, qualified by `chipselect`.
- `writedata` input 32: write data.
- `in_port` input WIDTH: external inputs, asynchronous to `clk`.
- `readdata` output 32: registered read data.
- `irq` output 1: registered level interrupt, active high.

## Operation
- Register map:
  - 0 DATA (RO): synchronised input value.
  - 1: reads 0, writes ignored.
  - 2 IRQMASK (RW): bits [WIDTH-1:0].
  - 3 EDGECAP (RO, write-1-to-clear).
  - Bits above WIDTH read 0.
- Synchroniser: `in_port` passes through SYNC_STAGES flops to give `sync_q`. `prev_q` holds `sync_q` delayed one cycle.
- Edge detect per bit, evaluated every cycle:
  - rise = `sync_q & ~prev_q`
  - fall = `~sync_q & prev_q`
  - any = `sync_q ^ prev_q`
- Priming after reset:
  - A prime counter counts SYNC_STAGES+1 cycles after `reset_n` deasserts.
  - Edge detect is forced to 0 until the counter saturates.
  - An input held high through reset therefore never produces a spurious capture.
- EDGECAP bit update:
  - Sets on a detected edge.
  - Clears when `chipselect & ~write_n & address==3 & writedata[i]`.
  - Set wins over clear in the same cycle.
- IRQMASK write: `chipselect & ~write_n & address==2` loads `writedata[WIDTH-1:0]`.
- `readdata` updates every cycle, as in the existing PIO:
  - It loads the zero-extended mux of the register selected by `address`.
  - It does not depend on `chipselect`.
- `irq` is registered: next value = `|(EDGECAP & IRQMASK)`, using register values.
- Reset values:
  - `readdata` = 0, `irq` = 0.
  - EDGECAP, IRQMASK, synchroniser, `prev_q` and prime counter = 0.
- Reset asserted mid-operation immediately clears all of the above.
  - Pending captures are lost.
  - Priming restarts after deassertion.

## Timing
- Read latency is 1 cycle: `readdata` is valid on the edge after the cycle `address` is presented.
- Input to DATA, with `in_port` changing before edge 0: `sync_q` is valid after edge SYNC_STAGES-1. DATA is visible on `readdata` one edge later.
- Input to EDGECAP with SYNC_STAGES=2: change before edge 0 gives the bit set after edge 2.
- EDGECAP to `irq`: +1 cycle, so after edge 3.
- W1C to `irq` deassert:
  - Clear takes effect on the write edge; `irq` falls one edge later.
  - This holds only if no new edge occurs on a masked-in bit.
- Mask write to `irq`: new mask applies one edge after the write; `irq` follows one edge later.
- Simultaneous read and write of the same address: `readdata` returns the pre-write value.

## Structure
- Shared package `pio_edge_in_pkg` holds:
  - address constants ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3;
  - edge-type constants EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2.
- One sub-module, `pio_sync_bus`: WIDTH-wide, SYNC_STAGES-deep synchroniser with async active-low reset. At depth 0 it is a pass-through.
- Top level holds edge detect, prime counter, registers, read mux and irq.

## Test plan
- Reset with `in_port`=8'hFF held high; release; wait 10 cycles. Required: EDGECAP reads 0, `irq`=0, DATA reads 32'h000000FF.
- EDGE_TYPE=0, IRQMASK=8'h01; pulse `in_port[0]` 0→1→0. Required: EDGECAP reads 32'h01; `irq` rises exactly 2 cycles after the bit-0 edge enters `sync_q`.
- Write 32'h01 to address 3. Required: EDGECAP reads 0; `irq` falls one cycle after the write.
- Issue a W1C of bit 3 in the same cycle a new rising edge on bit 3 is detected. Required: EDGECAP[3] remains 1.
- EDGE_TYPE=2, WIDTH=32; toggle bit 31. Required: EDGECAP=32'h80000000. With IRQMASK=0, `irq` stays 0. Setting IRQMASK[31] raises `irq` 2 cycles after the write.
- Assert `reset_n` low while EDGECAP=8'h5A and `irq`=1. Required: `readdata`, `irq` and all registers read 0 immediately, and no capture occurs during re-priming.

Source files
------------

// File: rtl/pio_edge_in_pkg.sv
// pio_edge_in_pkg: register addresses and edge-type codes shared by the PIO edge-capture block.
package pio_edge_in_pkg;
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/pio_sync_bus.sv
// pio_sync_bus: WIDTH-wide, STAGES-deep input synchroniser; depth 0 is a plain pass-through.
module pio_sync_bus #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);
  if (STAGES == 0) begin : g_pass
    logic unused_clk;
    assign unused_clk = clk ^ reset_n;
    assign sync_o = async_i;
  end else begin : g_sync
    logic [WIDTH-1:0] stage_q [STAGES];
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
      end else begin
        stage_q[0] <= async_i;
        for (int k = 1; k < STAGES; k++) stage_q[k] <= stage_q[k-1];
      end
    end
    assign sync_o = stage_q[STAGES-1];
  end
endmodule

// File: rtl/pio_edge_in.sv
// pio_edge_in: Avalon-MM input PIO with synchroniser, per-bit edge capture (W1C),
// interrupt mask and registered level interrupt.
module pio_edge_in
  import pio_edge_in_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  localparam logic [2:0] PRIME_MAX = 3'(SYNC_STAGES + 1);
  logic [WIDTH-1:0] sync_q, prev_q, det;
  logic [WIDTH-1:0] edgecap_q, edgecap_d, irqmask_q, irqmask_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [2:0]       prime_q;
  logic             irq_q, primed, wr, unused_wd;
  pio_sync_bus #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (in_port),
    .sync_o  (sync_q)
  );
  assign primed    = prime_q == PRIME_MAX;
  assign wr        = chipselect & ~write_n;
  assign unused_wd = ^writedata;
  // Edges are suppressed until the synchroniser and prev_q hold real post-reset samples.
  always_comb begin
    det = !primed                 ? '0 :
          EDGE_TYPE == EDGE_RISE  ? sync_q & ~prev_q :
          EDGE_TYPE == EDGE_FALL  ? ~sync_q & prev_q :
                                    sync_q ^ prev_q;
    irqmask_d  = (wr && address == ADDR_IRQMASK) ? writedata[WIDTH-1:0] : irqmask_q;
    edgecap_d  = (edgecap_q & ~((wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0)) | det;
    readdata_d = address == ADDR_DATA    ? 32'(sync_q) :
                 address == ADDR_IRQMASK ? 32'(irqmask_q) :
                 address == ADDR_EDGECAP ? 32'(edgecap_q) : '0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= '0;
      edgecap_q  <= '0;
      irqmask_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
      prime_q    <= '0;
    end else begin
      prev_q     <= sync_q;
      edgecap_q  <= edgecap_d;
      irqmask_q  <= irqmask_d;
      readdata_q <= readdata_d;
      irq_q      <= |(edgecap_q & irqmask_q);
      prime_q    <= primed ? prime_q : prime_q + 3'd1;
    end
  end
  assign readdata = readdata_q;
  assign irq      = irq_q;
endmodule

// File: tb/tb_pio_edge_in.sv
// tb_pio_edge_in: randomized scoreboard bench for three pio_edge_in configurations
// against a history-based reference model.
module tb_pio_edge_in;
  localparam int          STG [3] = '{2, 3, 0};
  localparam int          ET  [3] = '{0, 2, 1};
  localparam logic [31:0] WM  [3] = '{32'hFF, 32'hFFFF_FFFF, 32'h1F};
  typedef struct packed {
    logic [2:0][31:0] rd;
    logic [2:0]       ir;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect, write_n;
  logic [31:0] writedata, in32;
  logic [31:0] rd [3];
  logic        ir [3];
  exp_t        expq [$];
  logic [31:0] hist [$];
  logic [31:0] cap_m [3], mask_m [3];
  int          e, total = 0, passed = 0;
  always #5 clk = ~clk;
  pio_edge_in #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0)) u0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in32[7:0]),
    .readdata(rd[0]), .irq(ir[0]));
  pio_edge_in #(.WIDTH(32), .SYNC_STAGES(3), .EDGE_TYPE(2)) u1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in32),
    .readdata(rd[1]), .irq(ir[1]));
  pio_edge_in #(.WIDTH(5), .SYNC_STAGES(0), .EDGE_TYPE(1)) u2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in32[4:0]),
    .readdata(rd[2]), .irq(ir[2]));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  function automatic logic [31:0] hget(input int j);
    return j < 0 ? 32'h0 : hist[j];
  endfunction
  // The input applied before edge j reaches the DATA view S edges later;
  // capture compares consecutive samples once S+1 edges have passed since reset.
  task automatic issue(input logic [1:0] a, input logic cs, input logic wn,
                       input logic [31:0] wd, input logic [31:0] inv);
    exp_t x;
    logic [31:0] cur, prv, det;
    logic w;
    address = a; chipselect = cs; write_n = wn; writedata = wd; in32 = inv;
    hist.push_back(inv);
    w = cs && !wn;
    for (int i = 0; i < 3; i++) begin
      cur = hget(e - STG[i]) & WM[i];
      prv = hget(e - STG[i] - 1) & WM[i];
      det = (e < STG[i] + 1) ? 32'h0 :
            ET[i] == 0 ? (cur & ~prv) : ET[i] == 1 ? (~cur & prv) : (cur ^ prv);
      det &= WM[i];
      x.rd[i] = a == 2'd0 ? cur : a == 2'd2 ? mask_m[i] : a == 2'd3 ? cap_m[i] : 32'h0;
      x.ir[i] = |(cap_m[i] & mask_m[i]);
      cap_m[i] = ((cap_m[i] & ~((w && a == 2'd3) ? wd : 32'h0)) | det) & WM[i];
      if (w && a == 2'd2) mask_m[i] = wd & WM[i];
    end
    e++;
    expq.push_back(x);
  endtask
  task automatic step(input logic [1:0] a, input logic cs, input logic wn,
                      input logic [31:0] wd, input logic [31:0] inv);
    @(negedge clk);
    issue(a, cs, wn, wd, inv);
  endtask
  task automatic do_reset(input logic [31:0] inv);
    @(negedge clk);
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; in32 = inv;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_rd%0d", i), rd[i], 32'h0);
      chk($sformatf("rst_irq%0d", i), 32'(ir[i]), 32'h0);
    end
    hist.delete();
    e = 0;
    for (int i = 0; i < 3; i++) begin
      cap_m[i] = 32'h0;
      mask_m[i] = 32'h0;
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    issue(2'd3, 1'b0, 1'b1, 32'h0, inv);
  endtask
  task automatic rnd(input int n, inout logic [31:0] cur_in);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 2) == 0) cur_in ^= $urandom & $urandom;
      step(2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 1) != 0) ? $urandom : ($urandom & $urandom & $urandom), cur_in);
    end
  endtask
  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() != 0) begin
        x = expq.pop_front();
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("readdata%0d", i), rd[i], x.rd[i]);
          chk($sformatf("irq%0d", i), 32'(ir[i]), 32'(x.ir[i]));
        end
      end
    end
  end
  initial begin : stim
    logic [31:0] cur_in;
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'h0; in32 = 32'hFF; e = 0;
    do_reset(32'hFF);
    repeat (10) step(2'd3, 1'b0, 1'b1, 32'h0, 32'hFF);
    step(2'd0, 1'b0, 1'b1, 32'h0, 32'hFF);
    step(2'd3, 1'b0, 1'b1, 32'h0, 32'hFF);
    step(2'd2, 1'b1, 1'b0, 32'h1, 32'hFE);
    repeat (5) step(2'd3, 1'b0, 1'b1, 32'h0, 32'hFE);
    step(2'd3, 1'b0, 1'b1, 32'h0, 32'hFF);
    repeat (6) step(2'd3, 1'b0, 1'b1, 32'h0, 32'hFE);
    step(2'd3, 1'b1, 1'b0, 32'h1, 32'hFE);
    repeat (3) step(2'd3, 1'b0, 1'b1, 32'h0, 32'hFE);
    repeat (5) step(2'd3, 1'b0, 1'b1, 32'h0, 32'hF6);
    step(2'd3, 1'b0, 1'b1, 32'h0, 32'hFE);
    step(2'd3, 1'b0, 1'b1, 32'h0, 32'hFE);
    step(2'd3, 1'b1, 1'b0, 32'h8, 32'hFE);
    repeat (3) step(2'd3, 1'b0, 1'b1, 32'h0, 32'hFE);
    step(2'd2, 1'b1, 1'b0, 32'h0, 32'h0);
    repeat (6) step(2'd3, 1'b0, 1'b1, 32'h0, 32'h0);
    step(2'd3, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0);
    repeat (5) step(2'd3, 1'b0, 1'b1, 32'h0, 32'h8000_0000);
    repeat (5) step(2'd3, 1'b0, 1'b1, 32'h0, 32'h0);
    step(2'd2, 1'b1, 1'b0, 32'h8000_0000, 32'h0);
    repeat (4) step(2'd3, 1'b0, 1'b1, 32'h0, 32'h0);
    cur_in = 32'h0;
    rnd(400, cur_in);
    repeat (5) step(2'd0, 1'b0, 1'b1, 32'h0, 32'h0);
    step(2'd3, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0);
    step(2'd2, 1'b1, 1'b0, 32'hFF, 32'h0);
    repeat (5) step(2'd3, 1'b0, 1'b1, 32'h0, 32'h5A);
    do_reset(32'h5A);
    for (int k = 0; k < 10; k++) step(k[0] ? 2'd3 : 2'd0, 1'b0, 1'b1, 32'h0, 32'h5A);
    cur_in = 32'h5A;
    rnd(200, cur_in);
    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(expq.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
